vt_report_encoder: RTL



---
 rtl/vt_report_encoder.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/vt_report_encoder.sv
// vt_report_encoder
// Turns terminal-side events (key presses, cursor keys, cursor-position
// reports, device-attribute and status replies) into ASCII/escape byte
// streams for the UART transmitter.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   req_valid/req_ready request handshake; one request at a time
//   req_type            0 KEY_CHAR, 1 CUU, 2 CUD, 3 CUF, 4 CUB, 5 CPR, 6 DA, 7 DSR_OK
//   req_pn1, req_pn2    raw byte / row, column
//   app_cursor          DECCKM: 1 = cursor keys use ESC O instead of ESC [
//   tx_data/tx_valid/tx_ready  outgoing byte stream
//   busy                sequence in progress
//
// state  | meaning
// IDLE   | waiting for a request
// RAW    | emit raw key byte
// ESC    | emit 1B
// INTRO  | emit '[' or 'O'
// QMARK  | emit '?' (DA)
// NUM1   | emit decimal digits of pn1
// SEMI   | emit ';'
// NUM2   | emit decimal digits of pn2
// LIT    | emit literal body bytes of DA / DSR
// FINAL  | emit final byte, then back to IDLE
module vt_report_encoder #(
   parameter int PN_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_type,
   input  logic [PN_W-1:0] req_pn1,
   input  logic [PN_W-1:0] req_pn2,
   input  logic            app_cursor,
   output logic [7:0]      tx_data,
   output logic            tx_valid,
   input  logic            tx_ready,
   output logic            busy
);

   typedef enum logic [3:0] {
      S_IDLE, S_RAW, S_ESC, S_INTRO, S_QMARK,
      S_NUM1, S_SEMI, S_NUM2, S_LIT, S_FINAL
   } state_t;

   localparam logic [2:0] T_KEY = 3'd0;
   localparam logic [2:0] T_CUU = 3'd1;
   localparam logic [2:0] T_CUD = 3'd2;
   localparam logic [2:0] T_CUF = 3'd3;
   localparam logic [2:0] T_CUB = 3'd4;
   localparam logic [2:0] T_CPR = 3'd5;
   localparam logic [2:0] T_DA  = 3'd6;
   localparam logic [2:0] T_DSR = 3'd7;

   // Packed decimal form: {digit count[1:0], hundreds, tens, units}.
   function automatic logic [13:0] to_dec(input logic [PN_W-1:0] x);
      logic [PN_W-1:0] r;
      logic [3:0]      h;
      logic [3:0]      t;
      logic [1:0]      nd;
      r = x;
      h = 4'd0;
      t = 4'd0;
      for (int i = 0; i < 2; i++)
         if (r >= PN_W'(100)) begin
            r = r - PN_W'(100);
            h = h + 4'd1;
         end
      for (int i = 0; i < 9; i++)
         if (r >= PN_W'(10)) begin
            r = r - PN_W'(10);
            t = t + 4'd1;
         end
      nd = (x >= PN_W'(100)) ? 2'd3 : ((x >= PN_W'(10)) ? 2'd2 : 2'd1);
      return {nd, h, t, r[3:0]};
   endfunction

   // Digit position 0 = hundreds, 1 = tens, 2 = units.
   function automatic logic [7:0] dig_char(input logic [13:0] d, input logic [1:0] pos);
      logic [3:0] v;
      case (pos)
         2'd0:    v = d[11:8];
         2'd1:    v = d[7:4];
         default: v = d[3:0];
      endcase
      return {4'h3, v};
   endfunction

   state_t      state, state_nxt;
   logic [1:0]  dcnt, dcnt_nxt;
   logic [2:0]  typ;
   logic        app;
   logic [7:0]  raw;
   logic [13:0] d1, d2;
   logic        accept;
   logic [7:0]  data_c;

   assign req_ready = (state == S_IDLE);
   assign busy      = ~req_ready;
   assign tx_valid  = (state != S_IDLE);
   assign tx_data   = data_c;
   assign accept    = req_valid && req_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         dcnt  <= 2'd0;
         typ   <= 3'd0;
         app   <= 1'b0;
         raw   <= 8'h00;
         d1    <= 14'd0;
         d2    <= 14'd0;
      end else begin
         state <= state_nxt;
         dcnt  <= dcnt_nxt;
         if (accept) begin
            typ <= req_type;
            app <= app_cursor;
            raw <= req_pn1[7:0];
            d1  <= to_dec(req_pn1);
            d2  <= to_dec(req_pn2);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      dcnt_nxt  = dcnt;
      data_c    = 8'h00;
      case (state)
         S_IDLE: begin
            if (req_valid)
               state_nxt = (req_type == T_KEY) ? S_RAW : S_ESC;
         end
         S_RAW: begin
            data_c = raw;
            if (tx_ready) state_nxt = S_IDLE;
         end
         S_ESC: begin
            data_c = 8'h1B;
            if (tx_ready) state_nxt = S_INTRO;
         end
         S_INTRO: begin
            // 'O' only applies to cursor keys; reports always use CSI.
            data_c = (app && typ >= T_CUU && typ <= T_CUB) ? 8'h4F : 8'h5B;
            if (tx_ready) begin
               case (typ)
                  T_DA: state_nxt = S_QMARK;
                  T_CPR: begin
                     state_nxt = S_NUM1;
                     dcnt_nxt  = 2'd3 - d1[13:12];
                  end
                  T_DSR: begin
                     // DSR body is just '0', the last entry of the literal table.
                     state_nxt = S_LIT;
                     dcnt_nxt  = 2'd2;
                  end
                  default: state_nxt = S_FINAL;
               endcase
            end
         end
         S_QMARK: begin
            data_c = 8'h3F;
            if (tx_ready) begin
               state_nxt = S_LIT;
               dcnt_nxt  = 2'd0;
            end
         end
         S_NUM1: begin
            data_c = dig_char(d1, dcnt);
            if (tx_ready) begin
               if (dcnt == 2'd2) state_nxt = S_SEMI;
               else              dcnt_nxt  = dcnt + 2'd1;
            end
         end
         S_SEMI: begin
            data_c = 8'h3B;
            if (tx_ready) begin
               state_nxt = S_NUM2;
               dcnt_nxt  = 2'd3 - d2[13:12];
            end
         end
         S_NUM2: begin
            data_c = dig_char(d2, dcnt);
            if (tx_ready) begin
               if (dcnt == 2'd2) state_nxt = S_FINAL;
               else              dcnt_nxt  = dcnt + 2'd1;
            end
         end
         S_LIT: begin
            case (dcnt)
               2'd0:    data_c = 8'h31;
               2'd1:    data_c = 8'h3B;
               default: data_c = 8'h30;
            endcase
            if (tx_ready) begin
               if (dcnt == 2'd2) state_nxt = S_FINAL;
               else              dcnt_nxt  = dcnt + 2'd1;
            end
         end
         S_FINAL: begin
            case (typ)
               T_CUU:   data_c = 8'h41;
               T_CUD:   data_c = 8'h42;
               T_CUF:   data_c = 8'h43;
               T_CUB:   data_c = 8'h44;
               T_CPR:   data_c = 8'h52;
               T_DA:    data_c = 8'h63;
               T_DSR:   data_c = 8'h6E;
               default: data_c = 8'h00;
            endcase
            if (tx_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule
